// File: rtl/gd_down_timer.sv
// gd_down_timer: loadable down-counting timer with one-shot/periodic modes,
// pause enable and one-cycle expiry pulse. Define GD_DOWN_TIMER_PRESCALER_EN
// to divide decrement ticks by PRESCALE.
module gd_down_timer #(
    parameter int BITS     = 10,
    parameter int PRESCALE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic            enable,
    input  logic            periodic,
    input  logic [BITS-1:0] load_value,
    output logic [BITS-1:0] count,
    output logic            busy,
    output logic            expired
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_n;
    logic [BITS-1:0] count_n, reload, reload_n;
    logic            mode, mode_n, expired_n;
    logic            tick;

`ifdef GD_DOWN_TIMER_PRESCALER_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre;
    logic          clr_pre;

    assign tick    = enable && (pre == PW'(PRESCALE - 1));
    assign clr_pre = stop || start || (state == RUN && tick && count == BITS'(1) && !mode);

    // prescaler: advances on enabled RUN cycles, wraps on tick, clears on start/stop/one-shot expiry
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pre <= '0;
        else if (clr_pre)
            pre <= '0;
        else if (state == RUN && enable)
            pre <= tick ? '0 : pre + PW'(1);
    end
`else
    assign tick = enable;
`endif

    // next-state: stop beats start beats decrement; expiry pulse defaults low
    always_comb begin
        state_n   = state;
        count_n   = count;
        reload_n  = reload;
        mode_n    = mode;
        expired_n = 1'b0;
        if (stop) begin
            state_n = IDLE;
            count_n = '0;
        end else if (start) begin
            if (load_value == '0) begin
                state_n   = IDLE;
                count_n   = '0;
                expired_n = 1'b1;
            end else begin
                state_n  = RUN;
                count_n  = load_value;
                reload_n = load_value;
                mode_n   = periodic;
            end
        end else if (state == RUN && tick) begin
            if (count == BITS'(1)) begin
                expired_n = 1'b1;
                count_n   = mode ? reload : '0;
                state_n   = mode ? RUN : IDLE;
            end else begin
                count_n = count - BITS'(1);
            end
        end
    end

    // registered state and outputs; busy mirrors the next state so it is a clean flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            mode    <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            reload  <= reload_n;
            mode    <= mode_n;
            busy    <= (state_n == RUN);
            expired <= expired_n;
        end
    end
endmodule

// File: tb/tb_gd_down_timer.sv
// tb_gd_down_timer: directed scoreboard bench for gd_down_timer
module tb_gd_down_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       enable = 1'b0;
    logic       periodic = 1'b0;
    logic [9:0] load_value = '0;
    logic [9:0] count;
    logic       busy;
    logic       expired;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [9:0] c;
        logic       b;
        logic       e;
        string      tag;
    } exp_t;

    exp_t q[$];

    gd_down_timer #(.BITS(10), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
        .periodic(periodic), .load_value(load_value), .count(count), .busy(busy),
        .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic pop_check();
        exp_t x;
        x = q.pop_front();
        chk({x.tag, ".count"}, 32'(count), 32'(x.c));
        chk({x.tag, ".busy"}, 32'(busy), 32'(x.b));
        chk({x.tag, ".expired"}, 32'(expired), 32'(x.e));
    endtask

    // drive one cycle of inputs, record the expected post-edge outputs, then compare
    task automatic step(input logic st, input logic sp, input logic en, input logic per,
                        input logic [9:0] lv, input logic [9:0] ec, input logic eb,
                        input logic ee, input string tag);
        start = st; stop = sp; enable = en; periodic = per; load_value = lv;
        q.push_back('{c: ec, b: eb, e: ee, tag: tag});
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        #3;
        q.push_back('{c: 10'd0, b: 1'b0, e: 1'b0, tag: "reset"});
        pop_check();
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef GD_DOWN_TIMER_PRESCALER_EN
        step(1, 0, 1, 0, 10'd2, 10'd2, 1, 0, "ps_start");
        for (int i = 1; i <= 8; i++)
            step(0, 0, 1, 0, 10'd0, (i < 4) ? 10'd2 : (i < 8) ? 10'd1 : 10'd0,
                 i < 8, i == 8, $sformatf("ps_%0d", i));
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "ps_idle");
`else
        step(1, 0, 1, 0, 10'd3, 10'd3, 1, 0, "os_start");
        step(0, 0, 1, 0, 10'd0, 10'd2, 1, 0, "os_d1");
        step(0, 0, 1, 0, 10'd0, 10'd1, 1, 0, "os_d2");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 1, "os_exp");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "os_idle");

        step(1, 0, 1, 1, 10'd4, 10'd4, 1, 0, "per_start");
        for (int i = 1; i <= 20; i++)
            step(0, 0, 1, 0, 10'd0, 10'(4 - (i % 4)), 1, (i % 4) == 0,
                 $sformatf("per_%0d", i));
        step(0, 1, 1, 0, 10'd0, 10'd0, 0, 0, "per_stop");

        step(1, 0, 1, 0, 10'd5, 10'd5, 1, 0, "pause_start");
        step(0, 0, 1, 0, 10'd0, 10'd4, 1, 0, "pause_d1");
        step(0, 0, 1, 0, 10'd0, 10'd3, 1, 0, "pause_d2");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 10'd0, 10'd3, 1, 0, $sformatf("pause_hold%0d", i));
        step(0, 0, 1, 0, 10'd0, 10'd2, 1, 0, "pause_d3");
        step(0, 0, 1, 0, 10'd0, 10'd1, 1, 0, "pause_d4");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 1, "pause_exp");

        step(1, 0, 1, 0, 10'd0, 10'd0, 0, 1, "zero_start");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "zero_after");

        step(1, 0, 1, 0, 10'd6, 10'd6, 1, 0, "ss_start");
        step(1, 1, 1, 0, 10'd9, 10'd0, 0, 0, "ss_both");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "ss_after");

        step(1, 0, 1, 0, 10'd4, 10'd4, 1, 0, "rs_start");
        step(0, 0, 1, 0, 10'd0, 10'd3, 1, 0, "rs_d1");
        step(0, 0, 1, 0, 10'd0, 10'd2, 1, 0, "rs_d2");
        step(1, 0, 1, 0, 10'd7, 10'd7, 1, 0, "rs_restart");
        step(0, 0, 1, 0, 10'd0, 10'd6, 1, 0, "rs_d3");
        step(1, 0, 1, 0, 10'd0, 10'd0, 0, 1, "rs_zero");
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "rs_after");

        step(1, 0, 1, 0, 10'd2, 10'd2, 1, 0, "mode_start");
        step(0, 0, 1, 1, 10'd0, 10'd1, 1, 0, "mode_d1");
        step(0, 0, 1, 1, 10'd0, 10'd0, 0, 1, "mode_exp");

        step(1, 0, 1, 0, 10'd9, 10'd9, 1, 0, "ar_start");
        step(0, 0, 1, 0, 10'd0, 10'd8, 1, 0, "ar_d1");
        step(0, 0, 1, 0, 10'd0, 10'd7, 1, 0, "ar_d2");
        step(0, 0, 1, 0, 10'd0, 10'd6, 1, 0, "ar_d3");
        step(0, 0, 1, 0, 10'd0, 10'd5, 1, 0, "ar_d4");
        #2;
        reset = 1'b1;
        #1;
        q.push_back('{c: 10'd0, b: 1'b0, e: 1'b0, tag: "async_reset"});
        pop_check();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 0, 1, 0, 10'd0, 10'd0, 0, 0, "post_reset");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/gd_down_timer.md
Name: gd_down_timer

Overview:
- Loadable down-counting timer. It is the count-down counterpart of the general-use up counter in the accelerometer driver's Generic library.
- Used by the SPI/accelerometer control FSMs for chip-select setup/hold delays, sample-interval ticks and timeouts.
- Supports one-shot and periodic (auto-reload) modes, a pause enable and a single-cycle expiry pulse.

Parameters:
- BITS, 10, width of the count and load value.
- PRESCALE, 4, clock cycles per decrement tick. Used only when PRESCALER_EN is defined; legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  load load_value and begin counting; sampled on the rising edge.
- stop  input  1  abort counting; return to IDLE without expiry.
- enable  input  1  when low in RUN, count holds its value.
- periodic  input  1  mode select, latched at start: 1 = auto-reload, 0 = one-shot.
- load_value  input  BITS  terminal count N, latched at start.
- count  output  BITS  current remaining count (registered).
- busy  output  1  high while in RUN (registered).
- expired  output  1  one-cycle pulse on terminal count (registered).

Behaviour:
- Reset (asynchronous, clk-independent): state=IDLE, count=0, reload register=0, mode register=0, busy=0, expired=0. Prescaler counter=0.
- States: IDLE, RUN.
- Priority each edge: stop > start > enable/decrement.
- expired defaults to 0 every cycle unless set by the rules below, so it is never high for more than 1 cycle per event.
- IDLE, start=1, load_value=N>0:
  - count<=N, reload<=N, mode<=periodic, state<=RUN, busy<=1.
- IDLE, start=1, load_value=0:
  - count<=0, state stays IDLE, busy stays 0.
  - expired<=1 on the same edge, i.e. high for the following cycle.
- IDLE, no start: all outputs hold; expired=0.
- RUN, stop=1:
  - count<=0, state<=IDLE, busy<=0, expired stays 0.
  - stop and start together: stop wins.
- RUN, start=1 (no stop): restart.
  - Reload from the new load_value and latch the new mode; no expiry pulse.
  - The load_value=0 rule applies: go to IDLE with expired pulse.
- RUN, enable=1 (decrement tick), count>1: count<=count-1.
- RUN, tick, count==1:
  - expired<=1.
  - One-shot: count<=0, state<=IDLE, busy<=0.
  - Periodic: count<=reload, stay RUN.
- RUN, enable=0: count, state and prescaler hold.
- Timing:
  - Start sampled at edge k with N: expired is high during the cycle after edge k+N, given continuous enable.
  - Periodic: exactly N cycles between expired pulses.
- No wrap-around: count never underflows below 0 and never reaches 0 while in RUN.
- Arithmetic is unsigned BITS-wide.
- Reset mid-RUN: returns immediately to the reset values; no expiry pulse.
- The periodic input is ignored outside a start edge.

Optional Feature:
- Macro: GD_DOWN_TIMER_PRESCALER_EN.
- Defined:
  - An internal prescaler counter of width clog2(PRESCALE) advances in RUN when enable=1.
  - A decrement tick occurs only when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler clears on start, stop, reset and one-shot expiry. It holds when enable=0.
  - Start at edge k with N gives expired after edge k+N*PRESCALE.
- Undefined: no prescaler logic; every enabled RUN cycle is a tick. Timing is as in Behaviour.

Test Plan:
- Reset asserted mid-RUN with count=5 -> count=0, busy=0 and expired=0 immediately, asynchronously, before the next clk edge.
- One-shot: start with N=3, enable=1 -> count goes 3,2,1,0; expired high exactly 1 cycle after the 3rd decrement edge; busy falls with it; state IDLE.
- Periodic N=4 with enable held high for 20 cycles -> expired pulses every 4 cycles (5 pulses); count sequence 4,3,2,1,4,... busy stays 1.
- Pause: start N=5; enable=0 for 3 cycles after the 2nd decrement -> count holds at 3; expiry is delayed by exactly 3 cycles.
- Boundaries:
  - start with N=0 -> single expired pulse, busy stays 0.
  - stop and start asserted together in RUN -> IDLE, count=0, no pulse.
  - restart in RUN with N=7 at count=2 -> count=7, no pulse.
- PRESCALER_EN with PRESCALE=4, N=2 -> expired 8 cycles after start; count changes only every 4th enabled cycle.
